// File: rtl/instr_fetch_mem_if.sv
// rtl/instr_fetch_mem_if.sv - program load and instruction fetch bus for instr_fetch_mem
interface instr_fetch_mem_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic [3:0]  pc;
  logic [31:0] instruction;
  logic        prog_ready;
  logic [4:0]  prog_len;
  logic        overflow;

  modport master (
    output load_valid, load_data, load_last, reload, pc,
    input  load_ready, instruction, prog_ready, prog_len, overflow
  );

  modport slave (
    input  load_valid, load_data, load_last, reload, pc,
    output load_ready, instruction, prog_ready, prog_len, overflow
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - loadable instruction memory: LOAD accepts a program, RUN serves words by pc
module instr_fetch_mem #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_mem_if.slave bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic {LOAD, RUN} state_t;

  state_t      state;
  logic [4:0]  prog_len;
  logic        overflow;
  logic [31:0] instruction;
  logic [31:0] mem [DEPTH];

  logic          load_ready;
  logic          accept;
  logic          last_slot;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          pc_in_prog;

  assign load_ready = (state == LOAD) && (prog_len < DEPTH_L);
  assign accept     = bus.load_valid && load_ready;
  assign last_slot  = (prog_len == DEPTH_L - 5'd1);
  assign wr_addr    = prog_len[AW-1:0];
  assign rd_addr    = bus.pc[AW-1:0];
  assign pc_in_prog = ({1'b0, bus.pc} < prog_len);

  // Memory has no reset: contents survive reset/reload, but prog_len hides them.
  always_ff @(posedge clk) begin
    if (!reset && !bus.reload && accept) begin
      mem[wr_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      prog_len    <= 5'd0;
      overflow    <= 1'b0;
      instruction <= NOP_WORD;
    end else if (bus.reload) begin
      state       <= LOAD;
      prog_len    <= 5'd0;
      overflow    <= 1'b0;
      instruction <= NOP_WORD;
    end else begin
      case (state)
        LOAD: begin
          instruction <= NOP_WORD;
          if (accept) begin
            prog_len <= prog_len + 5'd1;
            if (bus.load_last || last_slot) begin
              state <= RUN;
            end
          end else if (bus.load_valid) begin
            overflow <= 1'b1;
          end
        end
        RUN: begin
          instruction <= pc_in_prog ? mem[rd_addr] : NOP_WORD;
        end
        default: begin
          state       <= LOAD;
          instruction <= NOP_WORD;
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.instruction = instruction;
  assign bus.prog_ready  = (state == RUN);
  assign bus.prog_len    = prog_len;
  assign bus.overflow    = overflow;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - directed vector bench for instr_fetch_mem at DEPTH 16 and DEPTH 4
module tb_instr_fetch_mem;
  logic clk;
  logic reset;

  instr_fetch_mem_if b16 ();
  instr_fetch_mem_if b4 ();

  instr_fetch_mem #(.DEPTH(16), .NOP_WORD(32'h0)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
  instr_fetch_mem #(.DEPTH(4),  .NOP_WORD(32'h0)) dut4  (.clk(clk), .reset(reset), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        rl;
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic [3:0]  pc;
    logic        e_lr;
    logic        e_pr;
    logic [4:0]  e_len;
    logic [31:0] e_ins;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic rl, logic lv, logic [31:0] ld, logic ll, logic [3:0] pc,
                              logic e_lr, logic e_pr, logic [4:0] e_len, logic [31:0] e_ins,
                              logic e_ovf);
    vec_t v;
    v.rl = rl; v.lv = lv; v.ld = ld; v.ll = ll; v.pc = pc;
    v.e_lr = e_lr; v.e_pr = e_pr; v.e_len = e_len; v.e_ins = e_ins; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic drive16(input logic rl, input logic lv, input logic [31:0] ld,
                         input logic ll, input logic [3:0] pc);
    b16.reload = rl; b16.load_valid = lv; b16.load_data = ld; b16.load_last = ll; b16.pc = pc;
  endtask

  task automatic drive4(input logic rl, input logic lv, input logic [31:0] ld,
                        input logic ll, input logic [3:0] pc);
    b4.reload = rl; b4.load_valid = lv; b4.load_data = ld; b4.load_last = ll; b4.pc = pc;
  endtask

  task automatic check16(input string tag, input logic lr, input logic pr, input logic [4:0] len,
                         input logic [31:0] ins, input logic ovf);
    check({tag, ".load_ready"},  32'(b16.load_ready), 32'(lr));
    check({tag, ".prog_ready"},  32'(b16.prog_ready), 32'(pr));
    check({tag, ".prog_len"},    32'(b16.prog_len),   32'(len));
    check({tag, ".instruction"}, b16.instruction,     ins);
    check({tag, ".overflow"},    32'(b16.overflow),   32'(ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive16(0, 0, 32'h0, 0, 4'd0);
    drive4(0, 0, 32'h0, 0, 4'd0);
    #2;
    check16("reset", 1, 0, 5'd0, 32'h0, 0);
    #10;
    reset = 1'b0;

    // Three-word program, fetch sweep, RUN-ignores-load, reload with load_valid
    vecs[0]  = mk(0, 1, 32'h2401_0005, 0, 4'd0, 1, 0, 5'd1, 32'h0, 0);
    vecs[1]  = mk(0, 1, 32'h2402_0003, 0, 4'd0, 1, 0, 5'd2, 32'h0, 0);
    vecs[2]  = mk(0, 1, 32'h0022_1821, 1, 4'd0, 0, 1, 5'd3, 32'h0, 0);
    vecs[3]  = mk(0, 0, 32'h0,         0, 4'd0, 0, 1, 5'd3, 32'h2401_0005, 0);
    vecs[4]  = mk(0, 0, 32'h0,         0, 4'd1, 0, 1, 5'd3, 32'h2402_0003, 0);
    vecs[5]  = mk(0, 0, 32'h0,         0, 4'd2, 0, 1, 5'd3, 32'h0022_1821, 0);
    vecs[6]  = mk(0, 0, 32'h0,         0, 4'd3, 0, 1, 5'd3, 32'h0, 0);
    vecs[7]  = mk(0, 1, 32'hDEAD_BEEF, 0, 4'd0, 0, 1, 5'd3, 32'h2401_0005, 0);
    vecs[8]  = mk(1, 1, 32'hDEAD_BEEF, 0, 4'd0, 1, 0, 5'd0, 32'h0, 0);
    vecs[9]  = mk(0, 1, 32'h1111_1111, 1, 4'd0, 0, 1, 5'd1, 32'h0, 0);
    vecs[10] = mk(0, 0, 32'h0,         0, 4'd0, 0, 1, 5'd1, 32'h1111_1111, 0);
    vecs[11] = mk(0, 0, 32'h0,         0, 4'd1, 0, 1, 5'd1, 32'h0, 0);

    for (int i = 0; i < 12; i++) begin
      drive16(vecs[i].rl, vecs[i].lv, vecs[i].ld, vecs[i].ll, vecs[i].pc);
      tick();
      check16($sformatf("vec%0d", i), vecs[i].e_lr, vecs[i].e_pr, vecs[i].e_len,
              vecs[i].e_ins, vecs[i].e_ovf);
    end

    // Reload during an accepting handshake in LOAD: the word must not be stored
    drive16(1, 0, 32'h0, 0, 4'd0); tick();
    drive16(0, 1, 32'h5555_0000, 0, 4'd0); tick();
    check("rl_load.len1", 32'(b16.prog_len), 32'd1);
    drive16(1, 1, 32'h6666_0001, 1, 4'd0); tick();
    check16("rl_load.win", 1, 0, 5'd0, 32'h0, 0);
    drive16(0, 1, 32'h7777_0000, 1, 4'd0); tick();
    check("rl_load.len_after", 32'(b16.prog_len), 32'd1);
    drive16(0, 0, 32'h0, 0, 4'd0); tick();
    check("rl_load.addr0", b16.instruction, 32'h7777_0000);

    // Full 16-word program without load_last, then a 17th word
    drive16(1, 0, 32'h0, 0, 4'd0); tick();
    for (int i = 0; i < 16; i++) begin
      drive16(0, 1, 32'hA000_0000 + 32'(i), 0, 4'd0);
      tick();
      if (i == 14) check("full.before_last_pr", 32'(b16.prog_ready), 32'd0);
    end
    check16("full.16", 0, 1, 5'd16, 32'h0, 0);
    drive16(0, 1, 32'hBBBB_BBBB, 0, 4'd15); tick();
    check16("full.17th", 0, 1, 5'd16, 32'hA000_000F, 0);
    drive16(0, 0, 32'h0, 0, 4'd0); tick();
    check("full.pc0", b16.instruction, 32'hA000_0000);

    // DEPTH=4: five words with load_last held low
    for (int i = 0; i < 5; i++) begin
      drive4(0, 1, 32'hC000_0000 + 32'(i), 0, 4'd3);
      tick();
      if (i == 3) begin
        check("d4.pr_at4", 32'(b4.prog_ready), 32'd1);
        check("d4.lr_at4", 32'(b4.load_ready), 32'd0);
      end
    end
    check("d4.len", 32'(b4.prog_len), 32'd4);
    check("d4.ovf", 32'(b4.overflow), 32'd0);
    check("d4.pc3", b4.instruction, 32'hC000_0003);
    drive4(0, 0, 32'h0, 0, 4'd0);

    // Asynchronous reset after 2 of 5 words
    drive16(1, 0, 32'h0, 0, 4'd0); tick();
    for (int i = 0; i < 2; i++) begin
      drive16(0, 1, 32'hE000_0000 + 32'(i), 0, 4'd0);
      tick();
    end
    check("areset.pre_len", 32'(b16.prog_len), 32'd2);
    drive16(0, 0, 32'h0, 0, 4'd0);
    #2;
    reset = 1'b1;
    #1;
    check16("areset.async", 1, 0, 5'd0, 32'h0, 0);
    #3;
    reset = 1'b0;
    drive16(0, 1, 32'h0BAD_C0DE, 1, 4'd0); tick();
    check16("areset.load1", 0, 1, 5'd1, 32'h0, 0);
    drive16(0, 0, 32'h0, 0, 4'd0); tick();
    check("areset.pc0", b16.instruction, 32'h0BAD_C0DE);
    drive16(0, 0, 32'h0, 0, 4'd1); tick();
    check("areset.pc1", b16.instruction, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of 32-bit instruction words stored.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, SHALL set the word returned for unloaded addresses (opcode 0, func 0, which the processor retires as invalid with no register write).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 load_valid  input  1  SHALL indicate that load_data carries a program word.
REQ-006 load_data  input  32  SHALL carry the program word to store.
REQ-007 load_last  input  1  SHALL mark the current load word as the final program word.
REQ-008 load_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-009 reload  input  1  SHALL be a single-cycle request to discard the program and re-enter loading.
REQ-010 pc  input  4  SHALL be the processor's instruction counter, used as the read address.
REQ-011 instruction  output  32  SHALL be the registered instruction word for pc.
REQ-012 prog_ready  output  1  SHALL be high while the block serves instructions (RUN state).
REQ-013 prog_len  output  5  SHALL be the number of words loaded, 0..DEPTH.
REQ-014 overflow  output  1  SHALL be a sticky flag for a load attempt made while the memory is full.

Function
REQ-015 The block SHALL implement a two-state FSM: LOAD (accept words) and RUN (serve words).
REQ-016 load_ready SHALL equal (state==LOAD) and (prog_len<DEPTH).
REQ-017 A word SHALL be accepted when load_valid and load_ready are both high on a rising edge: mem[prog_len] <= load_data and prog_len increments by 1.
REQ-018 LOAD->RUN SHALL occur on the edge that accepts a word with load_last=1, or on the edge that accepts the DEPTH-th word, whichever happens first.
REQ-019 load_valid while load_ready=0 in LOAD (memory full) SHALL set overflow; the word SHALL be dropped.
REQ-020 load_valid in RUN SHALL be ignored without setting overflow.
REQ-021 In RUN, instruction SHALL update one cycle after pc: instruction <= mem[pc] if pc<prog_len, else NOP_WORD.
REQ-022 In LOAD, instruction SHALL be driven to NOP_WORD.
REQ-023 reload=1 in any state SHALL on the next edge set state=LOAD, prog_len=0, overflow=0 and instruction=NOP_WORD; it SHALL NOT erase memory contents.
REQ-024 If reload and an accepting load handshake occur on the same edge, reload SHALL win and the word SHALL NOT be stored.
REQ-025 A load_last word with prog_len already at DEPTH-1 SHALL be stored and SHALL transition to RUN exactly once (no double count).
REQ-026 A pc value of 15 with DEPTH=16 and a full program SHALL return mem[15]; there is no wrap logic, because pc is 4 bits.
REQ-027 prog_len SHALL NOT exceed DEPTH under any stimulus.

Reset
REQ-028 reset SHALL force state=LOAD, prog_len=0, overflow=0, instruction=NOP_WORD, and prog_ready=0 immediately, independent of clk.
REQ-029 reset SHALL NOT clear memory contents; because prog_len=0, all reads return NOP_WORD until the block reloads.
REQ-030 Assertion of reset mid-load SHALL discard the partial program (prog_len=0); the first accepted word after release SHALL land at address 0.

Verification
REQ-031 The bench SHALL cover:
- Load 3 words (32'h2401_0005, 32'h2402_0003, 32'h0022_1821) with load_last on the third -> prog_ready=1, prog_len=3; pc=0,1,2,3 -> instruction equals the three words then 32'h0 one cycle later.
- Load 16 words with no load_last -> RUN entered after the 16th word, load_ready=0; a 17th load_valid is ignored and overflow stays 0.
- With DEPTH=4, drive 5 load_valid words and load_last held 0 -> RUN is entered after word 4, and no overflow is set because the FSM has already left LOAD.
- Assert reload in RUN together with load_valid -> next cycle state=LOAD, prog_len=0, word not stored, instruction=32'h0.
- Assert reset asynchronously after 2 of 5 words -> outputs go to reset values without a clock edge; reload 1 word with load_last -> pc=0 returns that word, pc=1 returns 32'h0.
